// File: rtl/dbus_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : dbus_mem_responder_pkg / dbus_mem_responder_if
// Purpose  : Data-bus request/response types and the bundle that carries
//            them between a core's memory stage (master) and a memory-side
//            responder (slave).
// Signals  : dreq  - request from the core: valid, addr, size, strobe, data.
//                    The master holds valid and the payload until data_ok.
//            dresp - response to the core: addr_ok, data_ok, data.
// Modports : master (drives dreq), slave (drives dresp).
// Revision : 1.0 - initial release
// ============================================================================

package dbus_mem_responder_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

endpackage

interface dbus_mem_responder_if;
    import dbus_mem_responder_pkg::*;

    dbus_req_t  dreq;
    dbus_resp_t dresp;

    modport master (output dreq, input  dresp);
    modport slave  (input  dreq, output dresp);
endinterface

`default_nettype wire

// File: rtl/dbus_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dbus_mem_responder
// Purpose  : Memory end of a core's data bus. Accepts one request at a time,
//            backs it with a 2**DEPTH_LOG2 x 64-bit word memory and answers
//            exactly LATENCY cycles after acceptance.
// Ports    : clk       - clock
//            reset     - asynchronous, active-low reset
//            bus       - dbus_mem_responder_if.slave (dreq in, dresp out)
//            busy      - a transaction is in flight
//            proto_err - sticky: payload changed while waiting
//            oor_cnt   - saturating count of out-of-range transactions
// Options  : DBUS_RESP_RANDOM_STALL_EN - when defined, a 16-bit LFSR adds
//            0..3 random wait cycles to every transaction.
// Revision : 1.0 - initial release
// ============================================================================

module dbus_mem_responder
    import dbus_mem_responder_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 10,
    parameter int          LATENCY    = 2,
    parameter logic [63:0] BASE       = 64'h8000_0000,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 reset,
    dbus_mem_responder_if.slave  bus,
    output logic                 busy,
    output logic                 proto_err,
    output logic [15:0]          oor_cnt
);

    localparam int c_DEPTH = 1 << DEPTH_LOG2;
`ifdef DBUS_RESP_RANDOM_STALL_EN
    localparam int c_EXTRA = 3;
`else
    localparam int c_EXTRA = 0;
`endif
    localparam int c_CNT_RAW = $clog2(LATENCY + c_EXTRA + 1);
    localparam int c_CNT_W   = (c_CNT_RAW < 1) ? 1 : c_CNT_RAW;

    generate
        if (LATENCY < 1) begin : g_latency_check
            $error("dbus_mem_responder: LATENCY must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [63:0]          r_addr;
    logic [7:0]           r_strobe;
    logic [63:0]          r_data;
    logic [63:0]          r_rdata;
    logic                 r_proto_err;
    logic [15:0]          r_oor_cnt;
    logic [63:0]          r_mem [0:c_DEPTH-1];

    logic [63:0]          w_sel_addr;
    logic [7:0]           w_sel_strobe;
    logic [63:0]          w_off;
    logic                 w_in_range;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [63:0]          w_rd_word;
    logic [c_CNT_W-1:0]   w_load;
    logic                 w_payload_diff;
    dbus_resp_t           w_resp;

    // In IDLE the request has not been latched yet, so address decode looks
    // at the live bus; afterwards it uses the latched copy so a requester
    // that misbehaves mid-transaction cannot redirect the access.
    assign w_sel_addr   = (r_state == S_IDLE) ? bus.dreq.addr   : r_addr;
    assign w_sel_strobe = (r_state == S_IDLE) ? bus.dreq.strobe : r_strobe;

    assign w_off      = w_sel_addr - BASE;
    assign w_in_range = (w_sel_addr >= BASE) && (w_off[63:DEPTH_LOG2+3] == '0);
    assign w_idx      = w_off[DEPTH_LOG2+2:3];
    assign w_rd_word  = (w_in_range && (w_sel_strobe == 8'h00)) ? r_mem[w_idx] : 64'h0;

    assign w_payload_diff = (bus.dreq.addr   != r_addr)   ||
                            (bus.dreq.strobe != r_strobe) ||
                            (bus.dreq.data   != r_data);

`ifdef DBUS_RESP_RANDOM_STALL_EN
    logic [15:0] r_lfsr;
    logic        w_lfsr_fb;

    // Fibonacci LFSR, taps 16,14,13,11.
    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end

    assign w_load = c_CNT_W'(LATENCY - 1) + c_CNT_W'(r_lfsr[1:0]);
`else
    assign w_load = c_CNT_W'(LATENCY - 1);
`endif

    // Transaction FSM. Read data is sampled on the edge that enters DONE;
    // a write commits on the edge that leaves DONE, and the next request
    // cannot reach its own DONE-entry read before that, so read-after-write
    // to the same word always observes the new data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_strobe    <= '0;
            r_data      <= '0;
            r_rdata     <= '0;
            r_proto_err <= 1'b0;
            r_oor_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.dreq.valid) begin
                        r_addr   <= bus.dreq.addr;
                        r_strobe <= bus.dreq.strobe;
                        r_data   <= bus.dreq.data;
                        r_cnt    <= w_load;
                        if (!w_in_range && (r_oor_cnt != 16'hFFFF)) begin
                            r_oor_cnt <= r_oor_cnt + 16'd1;
                        end
                        if (w_load == '0) begin
                            r_state <= S_DONE;
                            r_rdata <= w_rd_word;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!bus.dreq.valid) begin
                        // Core flush: drop the transaction silently.
                        r_state <= S_IDLE;
                    end else begin
                        if (w_payload_diff) begin
                            r_proto_err <= 1'b1;
                        end
                        r_cnt <= r_cnt - c_CNT_W'(1);
                        if (r_cnt == c_CNT_W'(1)) begin
                            r_state <= S_DONE;
                            r_rdata <= w_rd_word;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Byte-lane write, only if the requester is still present in DONE.
    // Memory is deliberately not reset; reset forces IDLE, which blocks it.
    always_ff @(posedge clk) begin
        if ((r_state == S_DONE) && bus.dreq.valid && (r_strobe != 8'h00) && w_in_range) begin
            for (int i = 0; i < 8; i++) begin
                if (r_strobe[i]) begin
                    r_mem[w_idx][8*i +: 8] <= r_data[8*i +: 8];
                end
            end
        end
    end

    // addr_ok is gated by reset so dresp reads all-zero while reset is held,
    // even with a requester still asserting valid. data_ok follows valid so
    // a flush during DONE suppresses the response in that same cycle.
    always_comb begin
        w_resp         = '0;
        w_resp.addr_ok = reset && (r_state == S_IDLE) && bus.dreq.valid;
        w_resp.data_ok = (r_state == S_DONE) && bus.dreq.valid;
        w_resp.data    = w_resp.data_ok ? r_rdata : 64'h0;
    end

    assign bus.dresp = w_resp;
    assign busy      = (r_state != S_IDLE);
    assign proto_err = r_proto_err;
    assign oor_cnt   = r_oor_cnt;

endmodule

`default_nettype wire
